scale_bcd_corrector: RTL and testbench



---
 rtl/scale_bcd_corrector.sv | 144 ++++++++++++++
 tb/tb_scale_bcd_corrector.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/scale_bcd_corrector.sv
// Display-path scale corrector: optionally scales one binary sample by a fixed-point
// constant, then converts it to packed BCD with a bit-serial shift-add-3 engine.
// One sample in flight at a time; ready/valid on both sides.

module scale_bcd_corrector #(
    parameter int unsigned     IN_W   = 30,
    parameter int unsigned     DIGITS = 6,
    parameter int unsigned     FRAC_W = 31,
    parameter logic [FRAC_W:0] SCALE  = (FRAC_W + 1)'(2037552085),
    parameter logic [IN_W-1:0] THRESH = IN_W'(950000000)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       in_value,
    input  logic                  in_force,
    input  logic                  corr_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_corrected,
    output logic                  out_ovf
);

    localparam int unsigned BCD_W  = 4 * DIGITS;
    // Full product width, so the scaled value can never wrap before truncation.
    localparam int unsigned PROD_W = IN_W + FRAC_W + 1;
    localparam int unsigned CNT_W  = $clog2(IN_W + 1);

    // 10^n evaluated at elaboration time.
    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    localparam logic [63:0]      OVF_LIMIT = pow10(DIGITS);
    localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        StIdle,
        StScale,
        StConvert,
        StDone
    } state_e;

    state_e             state_q;
    logic [IN_W-1:0]    work_q;     // captured sample, then scaled value, then shift register
    logic               apply_q;
    logic               ovf_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [CNT_W-1:0]   bit_cnt_q;

    logic [PROD_W-1:0]       scaled_wide;
    logic [PROD_W-1:0]       v_wide;
    logic                    ovf_calc;
    logic [BCD_W-1:0]        bcd_adj;
    logic [BCD_W+IN_W-1:0]   shift_cat;
    logic [BCD_W-1:0]        bcd_next;
    logic [IN_W-1:0]         work_next;

    assign in_ready = (state_q == StIdle);

    // Scale stage: truncating fixed-point multiply and the overflow decision.
    always_comb begin
        scaled_wide = (PROD_W'(work_q) * PROD_W'(SCALE)) >> FRAC_W;
        v_wide      = apply_q ? scaled_wide : PROD_W'(work_q);
        ovf_calc    = (v_wide >= PROD_W'(OVF_LIMIT));
    end

    // Double-dabble step: add 3 to nibbles >= 5, then shift the next binary bit in.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
            end
        end
        shift_cat = {bcd_adj, work_q} << 1;
    end

    assign bcd_next  = shift_cat[IN_W +: BCD_W];
    assign work_next = shift_cat[IN_W-1:0];

    // Sequencer with registered result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            work_q        <= '0;
            apply_q       <= 1'b0;
            ovf_q         <= 1'b0;
            bcd_q         <= '0;
            bit_cnt_q     <= '0;
            out_valid     <= 1'b0;
            out_bcd       <= '0;
            out_corrected <= 1'b0;
            out_ovf       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        work_q  <= in_value;
                        apply_q <= corr_en & (in_force | (in_value >= THRESH));
                        state_q <= StScale;
                    end
                end
                StScale: begin
                    work_q    <= v_wide[IN_W-1:0];
                    ovf_q     <= ovf_calc;
                    bcd_q     <= '0;
                    bit_cnt_q <= CNT_W'(IN_W - 1);
                    state_q   <= StConvert;
                end
                StConvert: begin
                    bcd_q  <= bcd_next;
                    work_q <= work_next;
                    if (bit_cnt_q == '0) begin
                        out_valid     <= 1'b1;
                        out_bcd       <= ovf_q ? ALL_NINES : bcd_next;
                        out_corrected <= apply_q;
                        out_ovf       <= ovf_q;
                        state_q       <= StDone;
                    end else begin
                        bit_cnt_q <= bit_cnt_q - 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scale_bcd_corrector.sv
// Directed bench for scale_bcd_corrector: default instance plus a low-threshold instance.

module tb_scale_bcd_corrector;

    localparam int unsigned IN_W   = 30;
    localparam int unsigned DIGITS = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic            sel;
    logic            in_valid;
    logic [IN_W-1:0] in_value;
    logic            in_force;
    logic            corr_en;
    logic            out_ready;

    logic            a_in_ready, a_out_valid, a_out_corrected, a_out_ovf;
    logic [23:0]     a_out_bcd;
    logic            b_in_ready, b_out_valid, b_out_corrected, b_out_ovf;
    logic [23:0]     b_out_bcd;

    logic            a_in_valid, b_in_valid;
    assign a_in_valid = in_valid & ~sel;
    assign b_in_valid = in_valid & sel;

    scale_bcd_corrector dut_a (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (a_in_valid),
        .in_ready      (a_in_ready),
        .in_value      (in_value),
        .in_force      (in_force),
        .corr_en       (corr_en),
        .out_valid     (a_out_valid),
        .out_ready     (out_ready),
        .out_bcd       (a_out_bcd),
        .out_corrected (a_out_corrected),
        .out_ovf       (a_out_ovf)
    );

    scale_bcd_corrector #(
        .THRESH (30'd1000)
    ) dut_b (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (b_in_valid),
        .in_ready      (b_in_ready),
        .in_value      (in_value),
        .in_force      (in_force),
        .corr_en       (corr_en),
        .out_valid     (b_out_valid),
        .out_ready     (out_ready),
        .out_bcd       (b_out_bcd),
        .out_corrected (b_out_corrected),
        .out_ovf       (b_out_ovf)
    );

    logic        m_in_ready, m_out_valid, m_out_corrected, m_out_ovf;
    logic [23:0] m_out_bcd;
    assign m_in_ready      = sel ? b_in_ready      : a_in_ready;
    assign m_out_valid     = sel ? b_out_valid     : a_out_valid;
    assign m_out_corrected = sel ? b_out_corrected : a_out_corrected;
    assign m_out_ovf       = sel ? b_out_ovf       : a_out_ovf;
    assign m_out_bcd       = sel ? b_out_bcd       : a_out_bcd;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full transaction with out_ready held high throughout.
    task automatic run_vec(input bit use_b, input logic [IN_W-1:0] val, input bit frc,
                           input bit en, input logic [23:0] exp_bcd, input bit exp_corr,
                           input bit exp_ovf, input string tag);
        int cyc;
        @(negedge clk);
        sel       = use_b;
        in_value  = val;
        in_force  = frc;
        corr_en   = en;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        check({tag, " in_ready"}, 32'(m_in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        cyc = 0;
        while (!m_out_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc + 1), 32'(IN_W + 2));
        check({tag, " bcd"}, 32'(m_out_bcd), 32'(exp_bcd));
        check({tag, " corrected"}, 32'(m_out_corrected), 32'(exp_corr));
        check({tag, " ovf"}, 32'(m_out_ovf), 32'(exp_ovf));
        @(posedge clk);
        #1 check({tag, " valid_drop"}, 32'(m_out_valid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit ok;
        int cyc;
        sel       = 1'b0;
        in_valid  = 1'b0;
        in_value  = '0;
        in_force  = 1'b0;
        corr_en   = 1'b1;
        out_ready = 1'b0;

        // Reset state
        #2;
        check("rst out_valid", 32'(a_out_valid), 32'd0);
        check("rst out_bcd", 32'(a_out_bcd), 32'd0);
        check("rst corrected", 32'(a_out_corrected), 32'd0);
        check("rst ovf", 32'(a_out_ovf), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        check("rst in_ready", 32'(a_in_ready), 32'd1);

        // Main function and boundaries
        run_vec(0, 30'd123456,    0, 1, 24'h123456, 0, 0, "bypass");
        run_vec(0, 30'd1048576,   1, 1, 24'h994898, 1, 0, "force");
        run_vec(0, 30'd500,       1, 1, 24'h000474, 1, 0, "force_small");
        run_vec(1, 30'd999,       0, 1, 24'h000999, 0, 0, "th_below");
        run_vec(1, 30'd1000,      0, 1, 24'h000948, 1, 0, "th_at");
        run_vec(1, 30'd1000,      0, 0, 24'h001000, 0, 0, "th_disabled");
        run_vec(1, 30'd1000,      1, 0, 24'h001000, 0, 0, "force_disabled");
        run_vec(0, 30'd1000000,   0, 1, 24'h999999, 0, 1, "ovf");
        run_vec(0, 30'd999999,    0, 1, 24'h999999, 0, 0, "max_fit");
        run_vec(0, 30'd0,         0, 1, 24'h000000, 0, 0, "zero");
        run_vec(0, 30'd949999999, 0, 1, 24'h999999, 0, 1, "dflt_th_below");
        run_vec(0, 30'd950000000, 0, 1, 24'h999999, 1, 1, "dflt_th_at");

        // Backpressure: hold result, ignore a second sample
        @(negedge clk);
        sel       = 1'b0;
        in_value  = 30'd42;
        in_force  = 1'b0;
        corr_en   = 1'b1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        cyc = 0;
        while (!a_out_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("bp valid", 32'(a_out_valid), 32'd1);
        ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i == 20) begin
                in_value = 30'd77;
                in_valid = 1'b1;
            end
            if (i == 21) in_valid = 1'b0;
            if (a_out_valid !== 1'b1 || a_out_bcd !== 24'h000042 || a_in_ready !== 1'b0) ok = 1'b0;
        end
        check("bp stable", 32'(ok), 32'd1);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp release valid", 32'(a_out_valid), 32'd0);
        check("bp release in_ready", 32'(a_in_ready), 32'd1);
        run_vec(0, 30'd55, 0, 1, 24'h000055, 0, 0, "bp_next");

        // Reset in the middle of a conversion
        @(negedge clk);
        sel      = 1'b0;
        in_value = 30'd123;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("mid_rst out_valid", 32'(a_out_valid), 32'd0);
        check("mid_rst out_bcd", 32'(a_out_bcd), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        check("mid_rst in_ready", 32'(a_in_ready), 32'd1);
        ok = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (a_out_valid !== 1'b0) ok = 1'b0;
        end
        check("mid_rst no_result", 32'(ok), 32'd1);
        run_vec(0, 30'd321, 0, 1, 24'h000321, 0, 0, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
